fxp_seq_divider: RTL and testbench

- Parametrised multi-cycle unsigned fixed-point divider: Quotient = floor(Dividend * 2^FRAC_W / Divisor).
- Successor to the hard-coded 16-bit / 8-bit program-2 division (24-bit, 16.8 result).
- Generalised operand widths and fraction bits, with a Start/Ack handshake, a divide-by-zero flag and optional rounding.
- Sits beside the CPU datapath as a memory-mapped or ALU-attached coprocessor.

---
 rtl/fxp_seq_divider.sv | 150 +++++++++++++++
 tb/tb_fxp_seq_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_seq_divider.sv
// Multi-cycle unsigned fixed-point divider: Quotient = floor(Dividend * 2^FRAC_W / Divisor).
// Define FXP_DIV_ROUND_EN for half-LSB upward rounding using one extra guard iteration.
module fxp_seq_divider #(
    parameter int DVD_W  = 16,
    parameter int DVS_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [DVD_W-1:0]        Dividend,
    input  logic [DVS_W-1:0]        Divisor,
    output logic                    Busy,
    output logic                    Ack,
    output logic [DVD_W+FRAC_W-1:0] Quotient,
    output logic [DVS_W-1:0]        Remainder,
    output logic                    DivZero
);
    localparam int Q_W = DVD_W + FRAC_W;
`ifdef FXP_DIV_ROUND_EN
    localparam int NUM_W = Q_W + 1;
`else
    localparam int NUM_W = Q_W;
`endif
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_r, state_nx_s;
    logic             busy_r, ack_r;
    logic [NUM_W-1:0] num_r, num_nx_s, num_load_s;
    logic [DVS_W:0]   rem_r, rem_nx_s, rem_shift_s, rem_diff_s;
    logic [DVS_W-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic [Q_W-1:0]   quotient_r, q_final_s;
    logic [DVS_W-1:0] remainder_r;
    logic             div_zero_r;
    logic             accept_s, dvs_zero_s, q_bit_s, last_s;

    // The numerator register doubles as the quotient: each step shifts a quotient bit in at the LSB.
    assign num_load_s = {Dividend, {(NUM_W-DVD_W){1'b0}}};
    assign dvs_zero_s = (Divisor == {DVS_W{1'b0}});
    assign last_s     = (cnt_r == CNT_LAST);

    // Request acceptance and next-state selection
    always_comb begin
        accept_s   = 1'b0;
        state_nx_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    accept_s   = 1'b1;
                    state_nx_s = dvs_zero_s ? S_DONE : S_RUN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // One restoring-division step; the top remainder bit is always clear but is folded in defensively
    always_comb begin
        rem_shift_s = {rem_r[DVS_W-1:0], num_r[NUM_W-1]};
        rem_diff_s  = rem_shift_s - {1'b0, dvs_r};
        q_bit_s     = rem_r[DVS_W] | (rem_shift_s >= {1'b0, dvs_r});
        if (q_bit_s) begin
            rem_nx_s = rem_diff_s;
        end else begin
            rem_nx_s = rem_shift_s;
        end
        num_nx_s = {num_r[NUM_W-2:0], q_bit_s};
    end

`ifdef FXP_DIV_ROUND_EN
    logic [Q_W:0] q_round_s;
    assign q_round_s = {1'b0, num_nx_s[NUM_W-1:1]} + {{Q_W{1'b0}}, num_nx_s[0]};
    assign q_final_s = q_round_s[Q_W] ? {Q_W{1'b1}} : q_round_s[Q_W-1:0];
`else
    assign q_final_s = num_nx_s;
`endif

    // State register with registered Busy/Ack decodes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == S_RUN);
            ack_r   <= (state_nx_s == S_DONE);
        end
    end

    // Working registers: operand capture and per-cycle iteration
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dvs_r <= {DVS_W{1'b0}};
            num_r <= {NUM_W{1'b0}};
            rem_r <= {(DVS_W+1){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            dvs_r <= Divisor;
            num_r <= num_load_s;
            rem_r <= {(DVS_W+1){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_RUN) begin
            num_r <= num_nx_s;
            rem_r <= rem_nx_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Result registers change only on the edge that enters DONE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            quotient_r  <= {Q_W{1'b0}};
            remainder_r <= {DVS_W{1'b0}};
            div_zero_r  <= 1'b0;
        end else if (accept_s && dvs_zero_s) begin
            quotient_r  <= {Q_W{1'b1}};
            remainder_r <= {DVS_W{1'b0}};
            div_zero_r  <= 1'b1;
        end else if ((state_r == S_RUN) && last_s) begin
            quotient_r  <= q_final_s;
            remainder_r <= rem_nx_s[DVS_W-1:0];
            div_zero_r  <= 1'b0;
        end
    end

    assign Busy      = busy_r;
    assign Ack       = ack_r;
    assign Quotient  = quotient_r;
    assign Remainder = remainder_r;
    assign DivZero   = div_zero_r;

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Scoreboard bench for fxp_seq_divider at default widths plus a narrow 8/4/4 instance.
module tb_fxp_seq_divider;
    localparam int DVD_W = 16, DVS_W = 8, FRAC_W = 8, Q_W = 24;
`ifdef FXP_DIV_ROUND_EN
    localparam int RND = 1;
    localparam logic [Q_W-1:0]   BASIC_Q  = 24'h402B;
    localparam logic [DVS_W-1:0] BASIC_R  = 8'd2;
    localparam logic [11:0]      NARROW_Q = 12'h42B;
    localparam logic [3:0]       NARROW_R = 4'd1;
`else
    localparam int RND = 0;
    localparam logic [Q_W-1:0]   BASIC_Q  = 24'h402A;
    localparam logic [DVS_W-1:0] BASIC_R  = 8'd4;
    localparam logic [11:0]      NARROW_Q = 12'h42A;
    localparam logic [3:0]       NARROW_R = 4'd2;
`endif
    localparam int LAT   = Q_W + RND;
    localparam int N_LAT = 12 + RND;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [DVD_W-1:0] Dividend = '0;
    logic [DVS_W-1:0] Divisor = '0;
    logic             Busy, Ack, DivZero;
    logic [Q_W-1:0]   Quotient;
    logic [DVS_W-1:0] Remainder;

    logic        n_start = 1'b0;
    logic [7:0]  n_dvd = '0;
    logic [3:0]  n_dvs = '0;
    logic        n_busy, n_ack, n_zero;
    logic [11:0] n_q;
    logic [3:0]  n_r;

    typedef struct { logic [Q_W-1:0] q; logic [DVS_W-1:0] r; logic z; } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    fxp_seq_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W), .FRAC_W(FRAC_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
        .Busy(Busy), .Ack(Ack), .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero));

    fxp_seq_divider #(.DVD_W(8), .DVS_W(4), .FRAC_W(4)) dut_narrow (
        .Clk(Clk), .Reset(Reset), .Start(n_start), .Dividend(n_dvd), .Divisor(n_dvs),
        .Busy(n_busy), .Ack(n_ack), .Quotient(n_q), .Remainder(n_r), .DivZero(n_zero));

    // Reference model: plain integer division of the scaled dividend
    task automatic push_model(input logic [DVD_W-1:0] dvd, input logic [DVS_W-1:0] dvs);
        exp_t e;
        longint unsigned n, q2, s;
        if (dvs == 0) begin
            e.q = {Q_W{1'b1}}; e.r = '0; e.z = 1'b1;
        end else begin
            n    = longint'(dvd) << (FRAC_W + RND);
            q2   = n / longint'(dvs);
            e.r  = DVS_W'(n % longint'(dvs));
            e.z  = 1'b0;
            if (RND == 1) begin
                s   = (q2 >> 1) + (q2 & 64'd1);
                e.q = (s > 64'hFFFFFF) ? {Q_W{1'b1}} : Q_W'(s);
            end else begin
                e.q = Q_W'(q2);
            end
        end
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.q = 'x; e.r = 'x; e.z = 1'bx;
        end
    endtask

    task automatic start_op(input logic [DVD_W-1:0] dvd, input logic [DVS_W-1:0] dvs);
        @(negedge Clk);
        Start = 1'b1; Dividend = dvd; Divisor = dvs;
        push_model(dvd, dvs);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Returns edges elapsed until Ack is seen, or -1 on timeout
    task automatic wait_ack(output int lat);
        lat = 0;
        while (Ack !== 1'b1 && lat < 200) begin
            @(negedge Clk);
            lat++;
        end
        if (Ack !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_checks++; if (Ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", Ack); end
        n_checks++; if (Quotient !== 24'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", Quotient); end
        n_checks++; if (Remainder !== 8'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", Remainder); end
        n_checks++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b want 0", DivZero); end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e; int lat;
        start_op(16'd385, 8'd6);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", Busy); end
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_lat: got %0d want %0d", lat, LAT); end
        n_checks++; if (Quotient !== BASIC_Q) begin n_fail++; $display("FAIL basic_q: got %h want %h", Quotient, BASIC_Q); end
        n_checks++; if (Remainder !== BASIC_R) begin n_fail++; $display("FAIL basic_r: got %0d want %0d", Remainder, BASIC_R); end
        n_checks++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL basic_z: got %b want 0", DivZero); end
        @(negedge Clk);
        n_checks++; if (Ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse: got %b want 0", Ack); end
    endtask

    task automatic test_edges();
        exp_t e; int lat;
        start_op(16'd3, 8'd255);
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (Quotient !== e.q || Remainder !== e.r) begin n_fail++; $display("FAIL small_div: got %h/%0d want %h/%0d", Quotient, Remainder, e.q, e.r); end
        start_op(16'hFFFF, 8'd1);
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL one_lat: got %0d want %0d", lat, LAT); end
        n_checks++; if (Quotient !== 24'hFFFF00) begin n_fail++; $display("FAIL one_q: got %h want FFFF00", Quotient); end
        n_checks++; if (Remainder !== 8'd0) begin n_fail++; $display("FAIL one_r: got %0d want 0", Remainder); end
    endtask

    task automatic test_divzero();
        exp_t e; int lat;
        start_op(16'h1234, 8'd0);
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dz_lat: got %0d want 0", lat); end
        n_checks++; if (Quotient !== 24'hFFFFFF) begin n_fail++; $display("FAIL dz_q: got %h want FFFFFF", Quotient); end
        n_checks++; if (DivZero !== 1'b1 || Remainder !== 8'd0) begin n_fail++; $display("FAIL dz_flag: got %b/%0d want 1/0", DivZero, Remainder); end
        start_op(16'd10, 8'd2);
        repeat (5) @(negedge Clk);
        n_checks++; if (Quotient !== 24'hFFFFFF || DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %h/%b want FFFFFF/1", Quotient, DivZero); end
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat + 5 !== LAT) begin n_fail++; $display("FAIL dz_next_lat: got %0d want %0d", lat + 5, LAT); end
        n_checks++; if (Quotient !== 24'h000500 || DivZero !== 1'b0) begin n_fail++; $display("FAIL dz_next: got %h/%b want 000500/0", Quotient, DivZero); end
    endtask

    task automatic test_start_ignored();
        exp_t e; int lat;
        start_op(16'd385, 8'd6);
        repeat (4) @(negedge Clk);
        Start = 1'b1; Dividend = 16'd100; Divisor = 8'd7;
        @(negedge Clk);
        Start = 1'b0;
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat + 5 !== LAT) begin n_fail++; $display("FAIL ign_lat: got %0d want %0d", lat + 5, LAT); end
        n_checks++; if (Quotient !== e.q || Remainder !== e.r) begin n_fail++; $display("FAIL ign_result: got %h/%0d want %h/%0d", Quotient, Remainder, e.q, e.r); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat;
        @(negedge Clk);
        Start = 1'b1; Dividend = 16'd50000; Divisor = 8'd201;
        push_model(16'd50000, 8'd201);
        @(negedge Clk);
        Dividend = 16'd777; Divisor = 8'd13;
        push_model(16'd777, 8'd13);
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_lat_a: got %0d want %0d", lat, LAT); end
        n_checks++; if (Quotient !== e.q || Remainder !== e.r) begin n_fail++; $display("FAIL b2b_a: got %h/%0d want %h/%0d", Quotient, Remainder, e.q, e.r); end
        @(negedge Clk);
        Start = 1'b0;
        n_checks++; if (Busy !== 1'b1 || Ack !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got busy %b ack %b want 1 0", Busy, Ack); end
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_lat_b: got %0d want %0d", lat, LAT); end
        n_checks++; if (Quotient !== e.q || Remainder !== e.r) begin n_fail++; $display("FAIL b2b_b: got %h/%0d want %h/%0d", Quotient, Remainder, e.q, e.r); end
    endtask

    task automatic test_reset_midrun();
        exp_t e; int lat; bit seen;
        start_op(16'd385, 8'd6);
        repeat (9) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        n_checks++; if (Busy !== 1'b0 || Ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: got busy %b ack %b want 0 0", Busy, Ack); end
        n_checks++; if (Quotient !== 24'h0 || Remainder !== 8'h0 || DivZero !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %h/%h/%b want 0", Quotient, Remainder, DivZero); end
        sb.delete();
        @(negedge Clk);
        Reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge Clk);
            if (Ack === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_noack: got %b want 0", seen); end
        start_op(16'd1000, 8'd7);
        wait_ack(lat);
        pop_exp(e);
        n_checks++; if (lat !== LAT || Quotient !== e.q || Remainder !== e.r) begin n_fail++; $display("FAIL mid_rst_after: got %0d %h/%0d want %0d %h/%0d", lat, Quotient, Remainder, LAT, e.q, e.r); end
    endtask

    task automatic test_random();
        exp_t e; int lat;
        for (int i = 0; i < 6; i++) begin
            start_op(DVD_W'($urandom_range(0, 65535)), DVS_W'($urandom_range(1, 255)));
            wait_ack(lat);
            pop_exp(e);
            n_checks++; if (lat !== LAT || Quotient !== e.q || Remainder !== e.r || DivZero !== e.z) begin
                n_fail++; $display("FAIL rand_%0d: got %0d %h/%0d want %0d %h/%0d", i, lat, Quotient, Remainder, LAT, e.q, e.r);
            end
        end
    endtask

    task automatic test_narrow();
        int lat;
        @(negedge Clk);
        n_start = 1'b1; n_dvd = 8'd200; n_dvs = 4'd3;
        @(negedge Clk);
        n_start = 1'b0;
        lat = 0;
        while (n_ack !== 1'b1 && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
        if (n_ack !== 1'b1) lat = -1;
        n_checks++; if (lat !== N_LAT) begin n_fail++; $display("FAIL narrow_lat: got %0d want %0d", lat, N_LAT); end
        n_checks++; if (n_q !== NARROW_Q || n_r !== NARROW_R) begin n_fail++; $display("FAIL narrow_result: got %h/%0d want %h/%0d", n_q, n_r, NARROW_Q, NARROW_R); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_divzero();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        test_narrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
